// File: rtl/fan_value_fnd_display.sv
// fan_value_fnd_display
//   Converts the fan controller's sensor word {humidity, temperature} to BCD
//   with a sequential double-dabble engine and drives a 4-digit multiplexed
//   7-segment display: humidity on the left pair, temperature on the right.
//   The auto-mode flag lights the decimal point of digit 2.
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLANK_LEADING 1 = blank a tens digit of 0, 0 = show it
//
// Ports
//   clk        system clock
//   reset_n    synchronous, active-low reset
//   value_data [15:8] humidity, [7:0] temperature, unsigned binary
//   auto_mode  lights the DP of digit 2 (left of the temperature pair)
//   seg_7      segments, active-low, {dp,g,f,e,d,c,b,a}
//   com        digit enables, active-low, bit3 = leftmost
//   bcd_valid  one-cycle pulse when new digits are latched for display
module fan_value_fnd_display #(
  parameter int SCAN_DIV      = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_data,
  input  logic        auto_mode,
  output logic [7:0]  seg_7,
  output logic [3:0]  com,
  output logic        bcd_valid
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        changed;
  logic        load;
  logic        shift_en;
  logic        done;

  logic [15:0] snapshot;
  logic [7:0]  bin_h;
  logic [7:0]  bin_t;
  logic [11:0] bcd_h;
  logic [11:0] bcd_t;
  logic [2:0]  step;

  logic [3:0]  hum_tens;
  logic [3:0]  hum_ones;
  logic [3:0]  tmp_tens;
  logic [3:0]  tmp_ones;
  logic        hum_ovf;
  logic        tmp_ovf;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx;
  logic             scan_wrap;
  logic [7:0]       seg_next;
  logic [3:0]       dig_sel;
  logic             ovf_sel;
  logic             is_tens;

  // One double-dabble step: correct every nibble >= 5, then shift in one bit.
  function automatic logic [11:0] dabble(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[10:0], bit_in};
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign changed = (value_data != snapshot);

  // Converter FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Converter FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = SHIFT;
      SHIFT:   if (step == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Converter FSM: outputs
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    load     = changed;
      SHIFT:   shift_en = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath and display registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snapshot  <= 16'h0000;
      bin_h     <= 8'h00;
      bin_t     <= 8'h00;
      bcd_h     <= 12'h000;
      bcd_t     <= 12'h000;
      step      <= 3'd0;
      hum_tens  <= 4'd0;
      hum_ones  <= 4'd0;
      tmp_tens  <= 4'd0;
      tmp_ones  <= 4'd0;
      hum_ovf   <= 1'b0;
      tmp_ovf   <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= done;
      if (load) begin
        snapshot <= value_data;
        bin_h    <= value_data[15:8];
        bin_t    <= value_data[7:0];
        bcd_h    <= 12'h000;
        bcd_t    <= 12'h000;
        step     <= 3'd0;
      end else if (shift_en) begin
        bcd_h <= dabble(bcd_h, bin_h[7]);
        bcd_t <= dabble(bcd_t, bin_t[7]);
        bin_h <= {bin_h[6:0], 1'b0};
        bin_t <= {bin_t[6:0], 1'b0};
        step  <= step + 3'd1;
      end
      if (done) begin
        hum_tens <= bcd_h[7:4];
        hum_ones <= bcd_h[3:0];
        tmp_tens <= bcd_t[7:4];
        tmp_ones <= bcd_t[3:0];
        hum_ovf  <= (bcd_h[11:8] != 4'd0);
        tmp_ovf  <= (bcd_t[11:8] != 4'd0);
      end
    end
  end

  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

  // Segment pattern for the slot currently selected by idx
  always_comb begin
    dig_sel = tmp_ones;
    ovf_sel = tmp_ovf;
    is_tens = 1'b0;
    case (idx)
      2'd0: begin dig_sel = tmp_ones; ovf_sel = tmp_ovf; is_tens = 1'b0; end
      2'd1: begin dig_sel = tmp_tens; ovf_sel = tmp_ovf; is_tens = 1'b1; end
      2'd2: begin dig_sel = hum_ones; ovf_sel = hum_ovf; is_tens = 1'b0; end
      2'd3: begin dig_sel = hum_tens; ovf_sel = hum_ovf; is_tens = 1'b1; end
      default: ;
    endcase
    if (ovf_sel)                                        seg_next = 8'hBF;
    else if (BLANK_LEADING && is_tens && dig_sel == 4'd0) seg_next = 8'hFF;
    else                                                seg_next = encode(dig_sel);
    // DP overrides blank and dash alike
    if (idx == 2'd2 && auto_mode) seg_next[7] = 1'b0;
  end

  // Scan stage: seg_7 and com are registered from the same idx so they switch together
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      seg_7    <= 8'hFF;
      com      <= 4'b1111;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) idx <= idx + 2'd1;
      com   <= ~(4'b0001 << idx);
      seg_7 <= seg_next;
    end
  end

endmodule

// File: tb/tb_fan_value_fnd_display.sv
// Scoreboard bench for fan_value_fnd_display. Two instances share the inputs:
// one with leading-zero blanking, one without. A transaction-level model of
// the converter pushes the expected value and its completion edge into a
// queue whenever a conversion would start; a negedge monitor pops on
// bcd_valid and checks the scanned segments against decimal arithmetic.
module tb_fan_value_fnd_display;

  localparam int SCAN_DIV = 4;
  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [3:0] COM_TAB [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_data = 16'h3719;
  logic        auto_mode = 1'b0;
  logic [7:0]  seg_7;
  logic [3:0]  com;
  logic        bcd_valid;
  logic [7:0]  seg_7_nb;
  logic [3:0]  com_nb;
  logic        bcd_valid_nb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    int          due;
  } conv_t;

  conv_t sb[$];
  int    ecount = 0;

  always #5 clk = ~clk;

  fan_value_fnd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .value_data(value_data), .auto_mode(auto_mode),
    .seg_7(seg_7), .com(com), .bcd_valid(bcd_valid)
  );

  fan_value_fnd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .value_data(value_data), .auto_mode(auto_mode),
    .seg_7(seg_7_nb), .com(com_nb), .bcd_valid(bcd_valid_nb)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pattern for slot idx from the decimal value of the selected byte
  function automatic logic [7:0] exp_seg(input logic [15:0] v, input int idx,
                                         input logic am, input bit blank);
    int b;
    logic [7:0] s;
    b = (idx < 2) ? int'(v[7:0]) : int'(v[15:8]);
    if (b > 99)                              s = 8'hBF;
    else if (idx % 2 == 0)                   s = SEG_TAB[b % 10];
    else if (blank && (b / 10) == 0)         s = 8'hFF;
    else                                     s = SEG_TAB[b / 10];
    if (idx == 2 && am) s[7] = 1'b0;
    return s;
  endfunction

  // Converter reference: accepts a new value only when idle, result 9 edges later
  initial begin
    logic [15:0] m_snap;
    int          m_busy;
    m_snap = 16'h0000;
    m_busy = 0;
    forever begin
      @(posedge clk);
      ecount++;
      if (!reset_n) begin
        m_snap = 16'h0000;
        m_busy = 0;
        sb.delete();
      end else if (m_busy == 0 && value_data != m_snap) begin
        m_snap = value_data;
        m_busy = 9;
        sb.push_back('{val: value_data, due: ecount + 9});
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
  end

  // Monitor: check outputs against the expectation formed before the last edge
  initial begin
    logic        armed;
    logic [7:0]  p_seg;
    logic [7:0]  p_seg_nb;
    logic [3:0]  p_com;
    logic [15:0] disp;
    logic        exp_v;
    int          c;
    int          idx;
    armed = 1'b0;
    disp = 16'h0000;
    c = 0;
    p_seg = 8'hFF; p_seg_nb = 8'hFF; p_com = 4'b1111;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("seg_7", 16'(seg_7), 16'(p_seg));
        chk("seg_7_noblank", 16'(seg_7_nb), 16'(p_seg_nb));
        chk("com", 16'(com), 16'(p_com));
        chk("com_noblank", 16'(com_nb), 16'(p_com));
        while (sb.size() > 0 && sb[0].due < ecount) void'(sb.pop_front());
        exp_v = (sb.size() > 0 && sb[0].due == ecount);
        chk("bcd_valid", 16'(bcd_valid), 16'(exp_v));
        chk("bcd_valid_noblank", 16'(bcd_valid_nb), 16'(exp_v));
        if (exp_v) begin
          disp = sb[0].val;
          void'(sb.pop_front());
        end
      end
      if (!reset_n) begin
        p_seg = 8'hFF; p_seg_nb = 8'hFF; p_com = 4'b1111;
        c = 0;
        disp = 16'h0000;
        armed = 1'b1;
      end else begin
        idx = (c / SCAN_DIV) % 4;
        p_seg    = exp_seg(disp, idx, auto_mode, 1'b1);
        p_seg_nb = exp_seg(disp, idx, auto_mode, 1'b0);
        p_com    = COM_TAB[idx];
        c++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] b;
    case ($urandom_range(0, 7))
      0:       b = 8'd0;
      1:       b = 8'd9;
      2:       b = 8'd10;
      3:       b = 8'd99;
      4:       b = 8'd100;
      5:       b = 8'd255;
      default: b = 8'($urandom_range(0, 255));
    endcase
    return b;
  endfunction

  initial begin
    reset_n = 1'b0;
    value_data = 16'h3719;
    auto_mode = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(40);
    auto_mode = 1'b1;
    step(20);
    auto_mode = 1'b0;
    value_data = 16'h0507;
    step(40);
    value_data = 16'h6463;
    step(40);
    value_data = 16'hFF00;
    step(40);
    value_data = 16'h1111;
    step(3);
    value_data = 16'h2222;
    step(40);
    // Reset during the shift sequence, value held
    value_data = 16'h4242;
    step(5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(40);
    for (int i = 0; i < 150; i++) begin
      value_data = {pick_byte(), pick_byte()};
      auto_mode  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        step($urandom_range(1, 2));
        reset_n = 1'b1;
      end
      step($urandom_range(1, 25));
    end
    step(30);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_value_fnd_display.md
Name: fan_value_fnd_display

Overview:
Downstream consumer of the fan controller's 16-bit sensor word (value_data = {humidity[7:0], temperature[7:0]}, binary). It converts each byte to two BCD digits with a sequential double-dabble engine. It then drives a 4-digit multiplexed 7-segment display, showing humidity on the left pair and temperature on the right pair. The auto-mode flag lights a decimal-point separator.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
BLANK_LEADING, 1, 1 = blank a tens digit equal to 0; 0 = show it.

Ports:
clk  input  1  system clock
reset_n  input  1  reset; synchronous, active-low
value_data  input  16  [15:8] humidity, [7:0] temperature, unsigned binary
auto_mode  input  1  fan auto mode active; lights DP of digit 2
seg_7  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}
com  output  4  digit enables, active-low, bit3 = leftmost
bcd_valid  output  1  1-cycle pulse when new digits are latched for display

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - seg_7=8'hFF, com=4'b1111, bcd_valid=0.
  - snapshot=16'h0000, displayed digits=0/0/0/0, scan counter=0, digit index=0, FSM=IDLE.
  - Any in-progress conversion is aborted.
- Converter FSM, one state register:
  - IDLE: if value_data != snapshot, capture snapshot<=value_data and go to SHIFT (the capture edge is the LOAD). Otherwise stay.
  - SHIFT: 8 cycles. Each cycle, before shifting, add 3 to every BCD nibble >= 5, then left-shift binary into BCD. Both bytes are processed in parallel, each with 12-bit BCD (hundreds/tens/ones). A 3-bit counter counts 0..7.
  - DONE: 1 cycle. Latch the tens/ones of both bytes into the display registers, set per-byte overflow flag = (hundreds != 0), pulse bcd_valid. Return to IDLE.
- Latency: the value_data change is sampled at edge N; bcd_valid is high in cycle N+9, i.e. 10 edges to the display-register update.
- value_data changes during SHIFT/DONE are ignored. IDLE re-compares against the snapshot, so the newest value is converted next. There is no loss of the final value; intermediate values may be skipped.
- Overflow: a byte > 99 shows dash (8'hBF) on both of its digits.
- Scan:
  - Counter counts 0..SCAN_DIV-1. On the wrap cycle, digit index advances 0->1->2->3->0.
  - Index maps: 0 = temp ones, 1 = temp tens, 2 = humid ones, 3 = humid tens.
  - com = ~(4'b0001 << index).
  - seg_7 and com are registered together from the same index, so there is no glitch between digits.
  - First non-reset edge: com=4'b1110.
- Encoding (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF, dash=BF.
- Blanking: with BLANK_LEADING=1, a tens digit of 0 shows FF unless that byte's overflow flag is set. Ones digits are never blanked.
- DP: seg_7[7]=0 only while index=2 and auto_mode=1, sampled in the same cycle as the segment register. It applies over blank/dash as well.
- Display registers change only in DONE. The scan never stalls during conversion.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with value_data=16'h3719 -> seg_7=FF, com=1111, bcd_valid=0. Release -> bcd_valid pulses on the 10th edge after release.
- Normal value: value_data=16'h3719 (55 %, 25 C), SCAN_DIV=4 -> com walks 1110,1101,1011,0111 every 4 cycles with seg_7 92,A4,92,92. With auto_mode=1, the com=1011 slot shows 12.
- Blanking: 16'h0507 -> seg_7 F8,FF,92,FF. Same value with BLANK_LEADING=0 -> F8,C0,92,C0.
- Overflow/max: 16'h6463 (100, 99) -> 90,90,BF,BF. Then 16'hFF00 -> C0,FF,BF,BF.
- Mid-conversion change: 16'h1111, then 16'h2222 three cycles later -> first bcd_valid shows 17/17, second bcd_valid within 10 more cycles shows 34/34. Exactly two pulses.
- Reset mid-SHIFT: reset_n low for 1 cycle at SHIFT step 4 -> no bcd_valid, digits all 0. Reconversion of the held value completes 10 edges after release.
